// File: rtl/sha1_pad_pkg.sv
// ----------------------------------------------------------------------------
// sha1_pad_pkg
// Shared definitions for the SHA-1 message padder.
//   state_e       : padder FSM states
//   SHA1_BLOCK_W  : width of one padded message block in bits
//   SHA1_LEN_W    : width of the running message bit-length counter
//   PAD_BYTE      : the single '1' bit marker byte appended after the message
// ----------------------------------------------------------------------------
package sha1_pad_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        OUT  = 2'd1,
        OUT2 = 2'd2,
        XTRA = 2'd3
    } state_e;

    localparam int        SHA1_BLOCK_W = 512;
    localparam int        SHA1_LEN_W   = 64;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

endpackage

// File: rtl/sha1_pad_mask.sv
// ----------------------------------------------------------------------------
// sha1_pad_mask
// Combinational shaping of the final message word.
//   bytes_i       : valid bytes in the word, left-aligned (0 means all four)
//   data_i        : raw final message word, byte0 in [31:24]
//   word_o        : word with invalid bytes cleared and the pad byte inserted
//                   right after the last valid byte (when it fits)
//   padInWord_o   : 1 when the pad byte landed inside this word; 0 when the
//                   word was full and the pad byte belongs to the next word
// ----------------------------------------------------------------------------
module sha1_pad_mask
    import sha1_pad_pkg::*;
(
    input  logic [1:0]  bytes_i,
    input  logic [31:0] data_i,
    output logic [31:0] word_o,
    output logic        padInWord_o
);

    // Keep only the leading valid bytes; anything the sender left in the
    // trailing lanes is discarded so it never reaches the hash.
    always_comb begin
        word_o      = data_i;
        padInWord_o = 1'b0;
        case (bytes_i)
            2'd1: begin
                word_o      = {data_i[31:24], PAD_BYTE, 16'd0};
                padInWord_o = 1'b1;
            end
            2'd2: begin
                word_o      = {data_i[31:16], PAD_BYTE, 8'd0};
                padInWord_o = 1'b1;
            end
            2'd3: begin
                word_o      = {data_i[31:8], PAD_BYTE};
                padInWord_o = 1'b1;
            end
            default: begin
                word_o      = data_i;
                padInWord_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sha1_pad.sv
// ----------------------------------------------------------------------------
// sha1_pad
// Collects 32-bit big-endian message words into 512-bit SHA-1 blocks and
// appends the standard padding (0x80, zeros, 64-bit message bit length).
// Ports:
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_valid/in_ready   : message word handshake
//   in_data             : message word, byte0 in [31:24]
//   in_last, in_bytes   : final-word flag and its valid byte count (0 = 4)
//   out_valid/out_ready : padded block handshake
//   out_block           : padded block, word0 in [511:480]
//   out_last            : block is the final block of the message
//   busy                : a message is in progress or a block is pending
// ----------------------------------------------------------------------------
module sha1_pad
    import sha1_pad_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_data,
    input  logic                    in_last,
    input  logic [1:0]              in_bytes,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SHA1_BLOCK_W-1:0] out_block,
    output logic                    out_last,
    output logic                    busy
);

    state_e                 state_q, state_d;
    logic [3:0]             widx_q, widx_d;
    logic [SHA1_LEN_W-1:0]  bitlen_q, bitlen_d;
    logic [0:15][31:0]      block_q, block_d;
    logic                   outValid_q, outValid_d;
    logic                   outLast_q, outLast_d;
    // Set when the last word filled word 15 completely, so the pad byte has
    // to open the following length-only block.
    logic                   padNext_q, padNext_d;

    logic [31:0]            maskedWord;
    logic                   padInWord;
    logic [2:0]             kBytes;
    logic [SHA1_LEN_W-1:0]  bitlenNew;
    logic [4:0]             padIdx;

    sha1_pad_mask u_mask (
        .bytes_i     (in_bytes),
        .data_i      (in_data[31:0]),
        .word_o      (maskedWord),
        .padInWord_o (padInWord)
    );

    assign kBytes    = (in_bytes == 2'd0) ? 3'd4 : {1'b0, in_bytes};
    assign bitlenNew = bitlen_q + {58'd0, kBytes, 3'b000};
    // Word index holding the pad byte; 16 means it spills past this block.
    assign padIdx    = {1'b0, widx_q} + {4'd0, ~padInWord};

    assign in_ready  = (state_q == FILL);
    assign out_valid = outValid_q;
    assign out_last  = outLast_q;
    assign out_block = block_q;
    assign busy      = (state_q != FILL) || (widx_q != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            widx_q     <= 4'd0;
            bitlen_q   <= '0;
            block_q    <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            padNext_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            bitlen_q   <= bitlen_d;
            block_q    <= block_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
            padNext_q  <= padNext_d;
        end
    end

    // Block assembly and handshake sequencing. The block register is only
    // written in FILL and XTRA, so it holds steady while a block waits in
    // OUT or OUT2 for the downstream side.
    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        bitlen_d   = bitlen_q;
        block_d    = block_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        padNext_d  = padNext_q;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    if (!in_last) begin
                        block_d[widx_q] = in_data[31:0];
                        bitlen_d        = bitlen_q + 64'd32;
                        if (widx_q == 4'd15) begin
                            widx_d     = 4'd0;
                            outValid_d = 1'b1;
                            outLast_d  = 1'b0;
                            state_d    = OUT;
                        end else begin
                            widx_d = widx_q + 4'd1;
                        end
                    end else begin
                        block_d[widx_q] = maskedWord;
                        bitlen_d        = bitlenNew;
                        outValid_d      = 1'b1;
                        // Everything after the last word is zero except a
                        // pad byte that was pushed into the next word.
                        for (int i = 0; i < 16; i++) begin
                            if (5'(i) > {1'b0, widx_q}) begin
                                block_d[i] = (5'(i) == padIdx) ? {PAD_BYTE, 24'd0} : 32'd0;
                            end
                        end
                        if (padIdx <= 5'd13) begin
                            block_d[14] = bitlenNew[63:32];
                            block_d[15] = bitlenNew[31:0];
                            outLast_d   = 1'b1;
                            padNext_d   = 1'b0;
                            state_d     = OUT;
                        end else begin
                            outLast_d = 1'b0;
                            padNext_d = (padIdx == 5'd16);
                            state_d   = OUT2;
                        end
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    state_d    = FILL;
                    if (outLast_q) begin
                        bitlen_d  = '0;
                        widx_d    = 4'd0;
                        outLast_d = 1'b0;
                    end
                end
            end
            OUT2: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    state_d    = XTRA;
                end
            end
            XTRA: begin
                block_d     = '0;
                block_d[14] = bitlen_q[63:32];
                block_d[15] = bitlen_q[31:0];
                if (padNext_q) begin
                    block_d[0] = {PAD_BYTE, 24'd0};
                end
                outLast_d  = 1'b1;
                outValid_d = 1'b1;
                padNext_d  = 1'b0;
                state_d    = OUT;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_sha1_pad.sv
// ----------------------------------------------------------------------------
// tb_sha1_pad
// Self-checking bench for sha1_pad: a table of single-word messages with
// hand-computed blocks, multi-block messages checked against a byte-level
// SHA-1 padding model, plus backpressure and reset sequences.
// ----------------------------------------------------------------------------
module tb_sha1_pad;

    logic         clk;
    logic         rst_n;
    logic         inValid;
    logic         inReady;
    logic [31:0]  inData;
    logic         inLast;
    logic [1:0]   inBytes;
    logic         outValid;
    logic         outReady;
    logic [511:0] outBlock;
    logic         outLast;
    logic         busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  bytes;
        logic [31:0] expW0;
        logic [31:0] expW1;
        logic [31:0] expW15;
    } vec_t;

    vec_t vecs[4];

    sha1_pad #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .in_last   (inLast),
        .in_bytes  (inBytes),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_block (outBlock),
        .out_last  (outLast),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one word and hold it until the padder takes it.
    task automatic applyStimulus(input logic [31:0] data, input logic last, input logic [1:0] bytes);
        int cnt = 0;
        @(negedge clk);
        inValid = 1'b1;
        inData  = data;
        inLast  = last;
        inBytes = bytes;
        while (!inReady && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (!inReady) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    // Wait for a block, capture it and complete the handshake.
    task automatic takeBlock(output logic [511:0] blk, output logic last);
        int cnt = 0;
        @(negedge clk);
        while (!outValid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        blk  = outBlock;
        last = outLast;
        if (!outValid) begin
            checks++;
            errors++;
            $display("[TB] FAIL out_valid timeout: got 0 expected 1");
            blk  = '0;
            last = 1'b0;
        end else begin
            outReady = 1'b1;
            @(posedge clk);
            #1;
            outReady = 1'b0;
        end
    endtask

    function automatic logic [7:0] msgByte(input int pos);
        return 8'((pos * 7 + 3) & 255);
    endfunction

    // Standard SHA-1 padding worked out byte by byte over the whole stream.
    function automatic logic [511:0] modelBlock(input int len, input int b);
        logic [511:0] blk = '0;
        logic [63:0]  bl  = 64'(len) * 64'd8;
        int nb    = (len + 8) / 64 + 1;
        int total = nb * 64;
        for (int i = 0; i < 64; i++) begin
            int pos = b * 64 + i;
            logic [7:0] v;
            if (pos < len)              v = msgByte(pos);
            else if (pos == len)        v = 8'h80;
            else if (pos >= total - 8)  v = 8'(bl >> (8 * (7 - (pos - (total - 8)))));
            else                        v = 8'h00;
            blk[511 - 8 * i -: 8] = v;
        end
        return blk;
    endfunction

    task automatic sendMsg(input int len);
        int nw = (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] word;
            for (int j = 0; j < 4; j++) begin
                int pos = 4 * w + j;
                word[31 - 8 * j -: 8] = (pos < len) ? msgByte(pos) : 8'hFF;
            end
            applyStimulus(word, w == nw - 1, 2'(len % 4));
        end
    endtask

    task automatic collectMsg(input int len, output logic [511:0] lastBlk);
        int nb = (len + 8) / 64 + 1;
        logic [511:0] blk;
        logic         last;
        lastBlk = '0;
        for (int b = 0; b < nb; b++) begin
            takeBlock(blk, last);
            checkOutput($sformatf("len%0d block%0d", len, b), blk, modelBlock(len, b));
            checkOutput($sformatf("len%0d block%0d out_last", len, b), {511'd0, last}, {511'd0, b == nb - 1});
            if (b == 0) lastBlk = blk;
            if (b == nb - 1) lastBlk = (nb == 1) ? blk : lastBlk;
        end
    endtask

    // Runs one message and returns its first and final blocks.
    task automatic runMessage(input int len, output logic [511:0] firstBlk, output logic [511:0] finalBlk);
        logic [511:0] f;
        fork
            sendMsg(len);
            collectMsg(len, f);
        join
        firstBlk = f;
        finalBlk = modelBlock(len, (len + 8) / 64);
        checkOutput($sformatf("len%0d busy after", len), {511'd0, busy}, 512'd0);
    endtask

    initial begin
        logic [511:0] blk, exp, held, b1, bLast;
        logic         last;

        vecs[0] = '{32'h61626300, 2'd3, 32'h61626380, 32'h00000000, 32'h00000018};
        vecs[1] = '{32'h61FFFFFF, 2'd1, 32'h61800000, 32'h00000000, 32'h00000008};
        vecs[2] = '{32'h6162ABCD, 2'd2, 32'h61628000, 32'h00000000, 32'h00000010};
        vecs[3] = '{32'h61626364, 2'd0, 32'h61626364, 32'h80000000, 32'h00000020};

        rst_n    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inLast   = 1'b0;
        inBytes  = 2'd0;
        outReady = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", {511'd0, inReady}, {511'd0, 1'b1});
        checkOutput("reset out_valid", {511'd0, outValid}, 512'd0);
        checkOutput("reset out_last", {511'd0, outLast}, 512'd0);
        checkOutput("reset busy", {511'd0, busy}, 512'd0);
        checkOutput("reset out_block", outBlock, 512'd0);
        rst_n = 1'b1;

        // Single-word messages with hand-computed blocks.
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].data, 1'b1, vecs[v].bytes);
            takeBlock(blk, last);
            exp            = '0;
            exp[511:480]   = vecs[v].expW0;
            exp[479:448]   = vecs[v].expW1;
            exp[31:0]      = vecs[v].expW15;
            checkOutput($sformatf("vec%0d block", v), blk, exp);
            checkOutput($sformatf("vec%0d out_last", v), {511'd0, last}, {511'd0, 1'b1});
            checkOutput($sformatf("vec%0d busy", v), {511'd0, busy}, 512'd0);
        end

        // 55 bytes: pad and length fit in one block.
        runMessage(55, b1, bLast);
        checkOutput("len55 length word", {480'd0, b1[31:0]}, {480'd0, 32'h000001B8});
        // 56 bytes: pad opens word 14, length goes to a second block.
        runMessage(56, b1, bLast);
        checkOutput("len56 pad word14", {480'd0, b1[63:32]}, {480'd0, 32'h80000000});
        checkOutput("len56 length word", {480'd0, bLast[31:0]}, {480'd0, 32'h000001C0});
        // 64 bytes: full block, pad byte leads the extra block.
        runMessage(64, b1, bLast);
        checkOutput("len64 extra word0", {480'd0, bLast[511:480]}, {480'd0, 32'h80000000});
        checkOutput("len64 length word", {480'd0, bLast[31:0]}, {480'd0, 32'h00000200});
        // Pad in word 15 of a block, and a message crossing blocks.
        runMessage(63, b1, bLast);
        runMessage(120, b1, bLast);

        // Backpressure: the pending block must hold while out_ready stays low.
        applyStimulus(32'h61626300, 1'b1, 2'd3);
        @(negedge clk);
        held = outBlock;
        checkOutput("bp out_valid", {511'd0, outValid}, {511'd0, 1'b1});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("bp cycle%0d block", c), outBlock, held);
            checkOutput($sformatf("bp cycle%0d in_ready", c), {511'd0, inReady}, 512'd0);
        end
        takeBlock(blk, last);
        exp          = '0;
        exp[511:480] = 32'h61626380;
        exp[31:0]    = 32'h00000018;
        checkOutput("bp block", blk, exp);

        // Reset in the middle of a message discards it.
        for (int w = 0; w < 7; w++) applyStimulus(32'h11111111 * w, 1'b0, 2'd0);
        @(negedge clk);
        checkOutput("mid busy", {511'd0, busy}, {511'd0, 1'b1});
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset busy", {511'd0, busy}, 512'd0);
        checkOutput("mid reset out_valid", {511'd0, outValid}, 512'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h61626300, 1'b1, 2'd3);
        takeBlock(blk, last);
        checkOutput("post reset abc", blk, exp);
        checkOutput("post reset out_last", {511'd0, last}, {511'd0, 1'b1});

        // Reset while a block is waiting for the handshake.
        applyStimulus(32'h61626300, 1'b1, 2'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("hs reset out_valid", {511'd0, outValid}, 512'd0);
        checkOutput("hs reset out_block", outBlock, 512'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h61626300, 1'b1, 2'd3);
        takeBlock(blk, last);
        checkOutput("hs post reset abc", blk, exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
